// File: rtl/latch_stim_checker.sv
// Hardware stimulus generator and response checker for a level-sensitive D latch:
// drives d/gate, compares q/qn against a zero-delay reference and counts mismatches.
module latch_stim_checker #(
  parameter int unsigned D_PERIOD  = 4,
  parameter int unsigned G_PERIOD  = 5,
  parameter int unsigned NUM_STEPS = 200,
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             d_out,
  output logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned STEP_W = $clog2(NUM_STEPS);
  localparam int unsigned DDIV_W = (D_PERIOD > 1) ? $clog2(D_PERIOD) : 1;
  localparam int unsigned GDIV_W = (G_PERIOD > 1) ? $clog2(G_PERIOD) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [DDIV_W-1:0] D_LAST    = DDIV_W'(D_PERIOD - 1);
  localparam logic [GDIV_W-1:0] G_LAST    = GDIV_W'(G_PERIOD - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  ERR_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci LFSR step, taps 8,6,5,4, shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_t             r_state;
  state_t             w_state;
  logic [STEP_W-1:0]  r_step,   w_step;
  logic [DDIV_W-1:0]  r_d_div,  w_d_div;
  logic [GDIV_W-1:0]  r_g_div,  w_g_div;
  logic [7:0]         r_lfsr,   w_lfsr;
  logic               r_d_out,  w_d_out;
  logic               r_gate,   w_gate;
  logic               r_hold_q, w_hold_q;
  logic               r_known,  w_known;
  logic               r_busy,   w_busy;
  logic               r_done,   w_done;
  logic               r_pass,   w_pass;
  logic [CNT_W-1:0]   r_err,    w_err;

  logic               w_exp_q;
  logic               w_known_or_open;
  logic               w_mismatch;
  logic [CNT_W-1:0]   w_err_inc;
  logic [7:0]         w_lfsr_adv;

  assign d_out    = r_d_out;
  assign gate_out = r_gate;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Reference latch, mismatch detection and all next-state values.
  always_comb begin
    w_state    = r_state;
    w_step     = r_step;
    w_d_div    = r_d_div;
    w_g_div    = r_g_div;
    w_lfsr     = r_lfsr;
    w_d_out    = r_d_out;
    w_gate     = r_gate;
    w_hold_q   = r_hold_q;
    w_known    = r_known;
    w_busy     = r_busy;
    w_done     = r_done;
    w_pass     = r_pass;
    w_err      = r_err;

    // The latch is modelled as transparent within the cycle the gate is high.
    w_exp_q         = r_gate ? r_d_out : r_hold_q;
    w_known_or_open = r_known | r_gate;
    w_mismatch      = (w_known_or_open && (q_in != w_exp_q)) || (qn_in != ~q_in);
    w_err_inc       = (r_err == ERR_MAX) ? r_err : (r_err + CNT_W'(1));
    w_lfsr_adv      = lfsr_next(r_lfsr);

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state = ST_RUN;
          w_step  = {STEP_W{1'b0}};
          w_d_div = {DDIV_W{1'b0}};
          w_g_div = {GDIV_W{1'b0}};
          w_d_out = 1'b0;
          w_lfsr  = SEED;
          w_gate  = SEED[0];
          w_err   = ERR_ZERO;
          w_known = 1'b0;
          w_done  = 1'b0;
          w_pass  = 1'b0;
          w_busy  = 1'b1;
        end else begin
          w_state = r_state;
        end
      end

      ST_RUN: begin
        w_step = r_step + STEP_W'(1);

        if (r_d_div == D_LAST) begin
          w_d_div = {DDIV_W{1'b0}};
          w_d_out = ~r_d_out;
        end else begin
          w_d_div = r_d_div + DDIV_W'(1);
        end

        if (r_g_div == G_LAST) begin
          w_g_div = {GDIV_W{1'b0}};
          w_lfsr  = w_lfsr_adv;
          w_gate  = w_lfsr_adv[0];
        end else begin
          w_g_div = r_g_div + GDIV_W'(1);
        end

        w_hold_q = w_exp_q;
        w_known  = w_known_or_open;

        if (w_mismatch) begin
          w_err = w_err_inc;
        end else begin
          w_err = r_err;
        end

        // The final step's mismatch is already folded into w_err here.
        if (r_step == LAST_STEP) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (w_err == ERR_ZERO) && w_known_or_open;
        end else begin
          w_state = ST_RUN;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_pass  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= {STEP_W{1'b0}};
      r_d_div  <= {DDIV_W{1'b0}};
      r_g_div  <= {GDIV_W{1'b0}};
      r_lfsr   <= SEED;
      r_d_out  <= 1'b0;
      r_gate   <= 1'b0;
      r_hold_q <= 1'b0;
      r_known  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= ERR_ZERO;
    end else begin
      r_step   <= w_step;
      r_d_div  <= w_d_div;
      r_g_div  <= w_g_div;
      r_lfsr   <= w_lfsr;
      r_d_out  <= w_d_out;
      r_gate   <= w_gate;
      r_hold_q <= w_hold_q;
      r_known  <= w_known;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_pass   <= w_pass;
      r_err    <= w_err;
    end
  end

endmodule
